// File: rtl/poll_pkg.sv
// Shared constants, FSM state encoding and header layout for the 4-channel poll link receiver.
package poll_pkg;

  localparam int          NUM_CH    = 4;
  localparam int          PKT_LEN   = 128;
  localparam logic [31:0] HDR_MAGIC = 32'hADF9_0C00;

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int WCNT_W = $clog2(PKT_LEN);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    PAY  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] magic;
    logic [31:0] ch_id;
  } hdr_t;

  // Channel ids are 1-based on the wire; 0 and anything above NUM_CH are rejected.
  function automatic logic hdr_match(input hdr_t h);
    return (h.magic == HDR_MAGIC) && (h.ch_id >= 32'd1) && (h.ch_id <= 32'(NUM_CH));
  endfunction

endpackage

// File: rtl/pkt_seq_chk.sv
// Per-channel expected-sequence table and comparator for the poll link receiver.
// Only instantiated by poll_unpack when SEQ_CHECK_EN is defined.
module pkt_seq_chk
  import poll_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            seq_stb,
  input  logic [63:0]     seq_word,
  input  logic [CH_W-1:0] ch,
  input  logic            done,
  output logic            seq_err
);

  logic [63:0] exp_q [NUM_CH];
  logic [63:0] seq_q;
  logic        seq_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the expectation table is a memory but is still reset, because every channel must restart at 0.
      for (int i = 0; i < NUM_CH; i++) exp_q[i] <= '0;
      seq_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_stb && (seq_word != exp_q[ch]);
      if (seq_stb) seq_q <= seq_word;
      // Resync from the received value so a single gap produces only one error.
      if (done) exp_q[ch] <= seq_q + 64'd1;
    end
  end

  assign seq_err = seq_err_q;

endmodule

// File: rtl/poll_unpack.sv
// Receive side of the 4-channel poll link: frame parser and per-channel DCFIFO write demux.
// Optional sequence checking is enabled by defining SEQ_CHECK_EN.
module poll_unpack
  import poll_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    fifo_wrclk,
  input  logic                    rst,
  input  logic                    data_valid,
  input  logic [63:0]             up_data,
  input  logic [NUM_CH-1:0]       ch_wrfull,
  output logic [NUM_CH-1:0]       ch_wrreq,
  output logic [63:0]             ch_data,
  output logic                    pkt_done,
  output logic [CH_W-1:0]         pkt_ch,
  output logic                    hdr_err,
  output logic                    len_err,
  output logic                    ovf_err,
  output logic                    seq_err,
  output logic [CNT_W*NUM_CH-1:0] pkt_cnt
);

  state_e                          state_q;
  logic [CH_W-1:0]                 ch_q;
  logic [CH_W-1:0]                 pkt_ch_q;
  logic [WCNT_W-1:0]               wcnt_q;
  logic [NUM_CH-1:0]               ch_wrreq_q;
  logic [63:0]                     ch_data_q;
  logic                            pkt_done_q;
  logic                            hdr_err_q;
  logic                            len_err_q;
  logic                            ovf_err_q;
  logic [NUM_CH-1:0][CNT_W-1:0]    pkt_cnt_q;

  hdr_t            hdr_d;
  logic            hdr_ok_d;
  logic [CH_W-1:0] hdr_ch_d;
  logic            last_word_d;

  always_comb begin
    hdr_d       = hdr_t'(up_data);
    hdr_ok_d    = hdr_match(hdr_d);
    hdr_ch_d    = CH_W'(hdr_d.ch_id - 32'd1);
    last_word_d = (state_q == PAY) && data_valid && (wcnt_q == LAST_WORD);
  end

  always_ff @(posedge fifo_wrclk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      pkt_ch_q   <= '0;
      wcnt_q     <= '0;
      ch_wrreq_q <= '0;
      ch_data_q  <= '0;
      pkt_done_q <= 1'b0;
      hdr_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
      ch_wrreq_q <= '0;
      ch_data_q  <= up_data;
      pkt_done_q <= 1'b0;
      hdr_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (data_valid) begin
            if (hdr_ok_d) begin
              ch_q     <= hdr_ch_d;
              pkt_ch_q <= hdr_ch_d;
              state_q  <= SEQ;
            end else begin
              hdr_err_q <= 1'b1;
            end
          end
        end

        SEQ: begin
          if (data_valid) begin
            wcnt_q  <= '0;
            state_q <= PAY;
          end else begin
            len_err_q <= 1'b1;
            state_q   <= IDLE;
          end
        end

        PAY: begin
          if (data_valid) begin
            // A full FIFO drops the word but the packet still runs to completion.
            if (ch_wrfull[ch_q]) ovf_err_q <= 1'b1;
            else                 ch_wrreq_q[ch_q] <= 1'b1;
            wcnt_q <= wcnt_q + 1'b1;
            if (last_word_d) begin
              pkt_done_q      <= 1'b1;
              pkt_cnt_q[ch_q] <= pkt_cnt_q[ch_q] + 1'b1;
              state_q         <= IDLE;
            end
          end else begin
            len_err_q <= 1'b1;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SEQ_CHECK_EN
  pkt_seq_chk u_seq_chk (
    .clk      (fifo_wrclk),
    .rst      (rst),
    .seq_stb  ((state_q == SEQ) && data_valid),
    .seq_word (up_data),
    .ch       (ch_q),
    .done     (last_word_d),
    .seq_err  (seq_err)
  );
`else
  assign seq_err = 1'b0;
`endif

  assign ch_wrreq = ch_wrreq_q;
  assign ch_data  = ch_data_q;
  assign pkt_done = pkt_done_q;
  assign pkt_ch   = pkt_ch_q;
  assign hdr_err  = hdr_err_q;
  assign len_err  = len_err_q;
  assign ovf_err  = ovf_err_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_poll_unpack.sv
// Self-checking bench for poll_unpack: frame-level stimulus tables, directed corner cases and random frames.
module tb_poll_unpack;

  localparam int          NCH   = 4;
  localparam int          PLEN  = 128;
  localparam logic [31:0] MAGIC = 32'hADF9_0C00;
  localparam int          VW    = 203;

  logic           fifo_wrclk = 1'b0;
  logic           rst;
  logic           data_valid;
  logic [63:0]    up_data;
  logic [3:0]     ch_wrfull;
  logic [3:0]     ch_wrreq;
  logic [63:0]    ch_data;
  logic           pkt_done;
  logic [1:0]     pkt_ch;
  logic           hdr_err;
  logic           len_err;
  logic           ovf_err;
  logic           seq_err;
  logic [127:0]   pkt_cnt;

  poll_unpack #(.CNT_W(32)) dut (
    .fifo_wrclk (fifo_wrclk),
    .rst        (rst),
    .data_valid (data_valid),
    .up_data    (up_data),
    .ch_wrfull  (ch_wrfull),
    .ch_wrreq   (ch_wrreq),
    .ch_data    (ch_data),
    .pkt_done   (pkt_done),
    .pkt_ch     (pkt_ch),
    .hdr_err    (hdr_err),
    .len_err    (len_err),
    .ovf_err    (ovf_err),
    .seq_err    (seq_err),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 fifo_wrclk = ~fifo_wrclk;

  // One record per clock: inputs plus the outputs expected one cycle later.
  typedef struct {
    string       tag;
    logic        rst;
    logic        valid;
    logic [63:0] data;
    logic [3:0]  full;
    logic [3:0]  wrreq;
    logic        done, hdr, len, ovf, seq;
    logic [1:0]  pch;
    logic [127:0] cnt;
  } vec_t;

  typedef struct {
    logic [63:0] word;
    bit          ok;
    int          id;
  } hrec_t;

  vec_t  vq[$];
  hrec_t htab[8];

  int total = 0;
  int bad   = 0;
  int vidx  = 0;
  int n_wr, n_ovf, n_done, n_hdr, n_len, n_seq;

  // Frame-level reference state.
  logic [31:0] m_cnt     [NCH];
  logic [1:0]  m_pch;
  logic [63:0] m_exp_seq [NCH];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] packed_cnt();
    logic [127:0] r;
    for (int i = 0; i < NCH; i++) r[i*32 +: 32] = m_cnt[i];
    return r;
  endfunction

  function automatic vec_t blank(input string tag);
    vec_t v;
    v.tag   = tag;
    v.rst   = 1'b0;
    v.valid = 1'b0;
    v.data  = '0;
    v.full  = 4'($urandom);
    v.wrreq = '0;
    v.done  = 1'b0;
    v.hdr   = 1'b0;
    v.len   = 1'b0;
    v.ovf   = 1'b0;
    v.seq   = 1'b0;
    v.pch   = m_pch;
    v.cnt   = packed_cnt();
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]     = '0;
      m_exp_seq[i] = '0;
    end
    m_pch = '0;
  endtask

  task automatic push_reset(input string tag);
    vec_t v;
    model_reset();
    v       = blank(tag);
    v.rst   = 1'b1;
    v.valid = 1'b1;
    v.data  = {$urandom, $urandom};
    vq.push_back(v);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) vq.push_back(blank(tag));
  endtask

  task automatic bad_hdr(input string tag, input logic [63:0] word);
    vec_t v;
    v       = blank(tag);
    v.valid = 1'b1;
    v.data  = word;
    v.hdr   = 1'b1;
    vq.push_back(v);
  endtask

  // id 1..NCH; npay payload words (PLEN = complete); words f_lo..f_hi see a full FIFO.
  task automatic frame(input string tag, input int id, input logic [63:0] seq, input int npay,
                       input bit inc, input int f_lo, input int f_hi, input int pct,
                       input bit cut_seq, input bit no_tail);
    vec_t v;
    int   c;
    bit   f;
    c     = id - 1;
    m_pch = 2'(c);
    v       = blank(tag);
    v.valid = 1'b1;
    v.data  = {MAGIC, 32'(id)};
    vq.push_back(v);
    if (cut_seq) begin
      v     = blank(tag);
      v.len = 1'b1;
      vq.push_back(v);
      return;
    end
    v       = blank(tag);
    v.valid = 1'b1;
    v.data  = seq;
`ifdef SEQ_CHECK_EN
    v.seq   = (seq != m_exp_seq[c]);
`endif
    vq.push_back(v);
    for (int i = 0; i < npay; i++) begin
      if (i == PLEN - 1) begin
        m_cnt[c]     = m_cnt[c] + 32'd1;
        m_exp_seq[c] = seq + 64'd1;
      end
      v       = blank(tag);
      v.valid = 1'b1;
      v.data  = inc ? 64'(i) : {$urandom, $urandom};
      f       = (i >= f_lo && i <= f_hi) || ($urandom_range(99) < pct);
      v.full[c] = f;
      if (f) v.ovf = 1'b1;
      else   v.wrreq = 4'(1 << c);
      v.done  = (i == PLEN - 1);
      vq.push_back(v);
    end
    if (npay < PLEN && !no_tail) begin
      v     = blank(tag);
      v.len = 1'b1;
      vq.push_back(v);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [VW-1:0] act, exp;
    rst        = v.rst;
    data_valid = v.valid;
    up_data    = v.data;
    ch_wrfull  = v.full;
    @(posedge fifo_wrclk);
    #1;
    act = {ch_wrreq, (|ch_wrreq) ? ch_data : 64'd0, pkt_done, hdr_err, len_err, ovf_err, seq_err,
           pkt_ch, pkt_cnt};
    exp = {v.wrreq, (|v.wrreq) ? v.data : 64'd0, v.done, v.hdr, v.len, v.ovf, v.seq, v.pch, v.cnt};
    n_wr   += $countones(ch_wrreq);
    n_ovf  += int'(ovf_err);
    n_done += int'(pkt_done);
    n_hdr  += int'(hdr_err);
    n_len  += int'(len_err);
    n_seq  += int'(seq_err);
    check($sformatf("%s#%0d", v.tag, vidx), act, exp);
    vidx++;
  endtask

  task automatic run_queue();
    vec_t v;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      apply(v);
    end
  endtask

  task automatic clear_agg();
    n_wr = 0; n_ovf = 0; n_done = 0; n_hdr = 0; n_len = 0; n_seq = 0;
  endtask

  initial begin
    int kind, id, gap, np;
    logic [63:0] w, sq;

    htab[0] = '{{MAGIC, 32'd0},          1'b0, 0};
    htab[1] = '{{MAGIC, 32'd1},          1'b1, 1};
    htab[2] = '{{MAGIC, 32'd4},          1'b1, 4};
    htab[3] = '{{MAGIC, 32'd5},          1'b0, 0};
    htab[4] = '{{MAGIC, 32'hFFFF_FFFF},  1'b0, 0};
    htab[5] = '{{MAGIC ^ 32'd1, 32'd2},  1'b0, 0};
    htab[6] = '{{MAGIC, 32'd3},          1'b1, 3};
    htab[7] = '{{32'hDEAD_BEEF, 32'd1},  1'b0, 0};

    model_reset();
    clear_agg();

    // Reset state.
    push_reset("reset");
    push_reset("reset");
    idle("post_reset", 2);
    run_queue();

    // Header decode table; accepted headers are cut short in SEQ.
    clear_agg();
    for (int i = 0; i < 8; i++) begin
      if (htab[i].ok) frame("hdr_tab", htab[i].id, 64'd0, 0, 1'b0, -1, -1, 0, 1'b1, 1'b0);
      else            bad_hdr("hdr_tab", htab[i].word);
    end
    run_queue();
    check("hdr_tab_errs", VW'(n_hdr), VW'(5));
    check("hdr_tab_len", VW'(n_len), VW'(3));

    // T1: clean channel-2 packet carrying 0..127.
    clear_agg();
    frame("t1", 2, m_exp_seq[1], PLEN, 1'b1, -1, -1, 0, 1'b0, 1'b0);
    idle("t1", 2);
    run_queue();
    check("t1_writes", VW'(n_wr), VW'(128));
    check("t1_done", VW'(n_done), VW'(1));
    check("t1_cnt1", VW'(pkt_cnt[63:32]), VW'(1));

    // T2: ch1 then ch4 back-to-back.
    clear_agg();
    frame("t2a", 1, m_exp_seq[0], PLEN, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    frame("t2b", 4, m_exp_seq[3], PLEN, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    idle("t2", 1);
    run_queue();
    check("t2_writes", VW'(n_wr), VW'(256));
    check("t2_cnt", VW'({pkt_cnt[127:96], pkt_cnt[31:0]}), VW'({32'd1, 32'd1}));

    // T3: bad channel id then bad magic.
    clear_agg();
    bad_hdr("t3", {MAGIC, 32'd5});
    bad_hdr("t3", {32'hDEAD_BEEF, 32'd1});
    idle("t3", 1);
    run_queue();
    check("t3_hdr", VW'(n_hdr), VW'(2));
    check("t3_writes", VW'(n_wr), VW'(0));

    // T4: ch3 truncated after 60 words, then a clean ch3 packet.
    clear_agg();
    frame("t4a", 3, m_exp_seq[2], 60, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    run_queue();
    check("t4_trunc_writes", VW'(n_wr), VW'(60));
    check("t4_len", VW'(n_len), VW'(1));
    check("t4_cnt2", VW'(pkt_cnt[95:64]), VW'(0));
    frame("t4b", 3, m_exp_seq[2], PLEN, 1'b1, -1, -1, 0, 1'b0, 1'b0);
    run_queue();
    check("t4_cnt2_after", VW'(pkt_cnt[95:64]), VW'(1));

    // T5: FIFO full for words 10..19 of a ch1 packet.
    clear_agg();
    frame("t5", 1, m_exp_seq[0], PLEN, 1'b0, 10, 19, 0, 1'b0, 1'b0);
    run_queue();
    check("t5_writes", VW'(n_wr), VW'(118));
    check("t5_ovf", VW'(n_ovf), VW'(10));
    check("t5_done", VW'(n_done), VW'(1));

    // T7: last word dropped, pkt_done and ovf_err together.
    clear_agg();
    frame("t7", 2, m_exp_seq[1], PLEN, 1'b0, 127, 127, 0, 1'b0, 1'b0);
    run_queue();
    check("t7_ovf", VW'(n_ovf), VW'(1));
    check("t7_done", VW'(n_done), VW'(1));

    // T6: reset mid-packet, then ch2 sequences 0,1,3,4.
    clear_agg();
    frame("t6_cut", 2, m_exp_seq[1], 30, 1'b0, -1, -1, 0, 1'b0, 1'b1);
    push_reset("t6_rst");
    idle("t6_rst", 1);
    frame("t6", 2, 64'd0, PLEN, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    frame("t6", 2, 64'd1, PLEN, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    frame("t6", 2, 64'd3, PLEN, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    frame("t6", 2, 64'd4, PLEN, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    run_queue();
    check("t6_done", VW'(n_done), VW'(4));
    check("t6_cnt1", VW'(pkt_cnt[63:32]), VW'(4));
`ifdef SEQ_CHECK_EN
    check("t6_seq", VW'(n_seq), VW'(1));
`else
    check("t6_seq", VW'(n_seq), VW'(0));
`endif

    // Random frames against the frame-level model.
    for (int k = 0; k < 40; k++) begin
      gap = $urandom_range(2);
      idle("rnd", gap);
      kind = $urandom_range(9);
      id   = $urandom_range(NCH, 1);
      sq   = ($urandom_range(3) == 0) ? {$urandom, $urandom} : m_exp_seq[id-1];
      case (kind)
        0: begin
          w = {$urandom, $urandom};
          if (w[63:32] == MAGIC) w[63] = ~w[63];
          bad_hdr("rnd_bad", w);
        end
        1: frame("rnd_cut_seq", id, sq, 0, 1'b0, -1, -1, 0, 1'b1, 1'b0);
        2: begin
          np = $urandom_range(PLEN - 1);
          frame("rnd_cut_pay", id, sq, np, 1'b0, -1, -1, 10, 1'b0, 1'b0);
        end
        default: frame("rnd_pkt", id, sq, PLEN, 1'b0, -1, -1, 10, 1'b0, 1'b0);
      endcase
      run_queue();
    end
    idle("end", 2);
    run_queue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
